step_ex_stm: RTL

Parameterised store-multiple execution step for the riscade sequencer. It is started by the shared active-low `ena_` strobe and latches an address, a data word and a beat count. It then performs one or more consecutive memory writes on the shared open-drain/tri-state bus, incrementing the address on each write, and reports completion on the shared `rdy_` line. Configurable bus widths, strobe timing and optional memory wait-states generalise the single fixed-width store step.

---
 rtl/step_pkg.sv | 17 +
 rtl/step_phase_timer.sv | 31 +++
 rtl/step_ex_stm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/step_pkg.sv
// Shared definitions for the riscade sequencer step blocks: FSM state encoding
// and the drive/release values used on the open-drain and tri-state lines.
package step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } step_state_e;

  localparam logic OD_ASSERT  = 1'b0;
  localparam logic OD_RELEASE = 1'bz;
  localparam logic TS_RELEASE = 1'bz;

endpackage

// File: rtl/step_phase_timer.sv
// Loadable down-counter with a terminal-count flag; times the SETUP and
// STROBE phases of a store beat.
module step_phase_timer #(
  parameter int TW = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          tc_o
);

  logic [TW-1:0] cnt_q;

  // Load takes priority; the count saturates at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/step_ex_stm.sv
// Store-multiple execution step: latches address/data/beat count on ena_ and
// writes len+1 consecutive words on the shared bus, then pulses rdy_.
// Optional feature macro: STEP_ST_WAIT_EN (mem_wait stretches the strobe).
module step_ex_stm
  import step_pkg::*;
#(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int LW     = 4,
  parameter int SETUP  = 1,
  parameter int WE_LEN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena_,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] r0_dout,
  input  logic [AW-1:0] r1_dout,
  input  logic          mem_wait,
  output wire           rdy_,
  output wire           mem_we_,
  output wire  [AW-1:0] abus,
  output wire  [DW-1:0] dbus,
  output logic          busy
);

  localparam int TMAX = (SETUP > WE_LEN) ? SETUP : WE_LEN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP - 1);
  localparam logic [TW-1:0] WE_LD    = TW'(WE_LEN - 1);

  step_state_e   state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [LW-1:0] cnt_q;
  logic          drive_q;
  logic          we_q;
  logic          rdy_q;
  logic          busy_q;

  logic          tmr_load_s;
  logic [TW-1:0] tmr_val_s;
  logic          tmr_dec_s;
  logic          tc_s;
  logic          wait_s;
  logic          strobe_end_s;

`ifdef STEP_ST_WAIT_EN
  assign wait_s = mem_wait;
`else
  // mem_wait stays on the port list but never influences the strobe.
  assign wait_s = 1'b0 & mem_wait;
`endif

  assign strobe_end_s = tc_s & ~wait_s;

  // Phase-timer control derived from the current state.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = SETUP_LD;
    tmr_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ena_) tmr_load_s = 1'b1;
        else       tmr_load_s = 1'b0;
      end
      ST_SETUP: begin
        if (tc_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = WE_LD;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_STROBE: begin
        if (!tc_s) tmr_dec_s = 1'b1;
        else       tmr_dec_s = 1'b0;
      end
      ST_HOLD: begin
        if (cnt_q != '0) tmr_load_s = 1'b1;
        else             tmr_load_s = 1'b0;
      end
      default: tmr_load_s = 1'b0;
    endcase
  end

  step_phase_timer #(.TW(TW)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .dec_i      (tmr_dec_s),
    .tc_o       (tc_s)
  );

  // Sequencer FSM; output enables are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      drive_q <= 1'b0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!ena_) begin
            addr_q  <= r1_dout;
            data_q  <= r0_dout;
            cnt_q   <= len;
            drive_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tc_s) begin
            we_q    <= 1'b1;
            state_q <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (strobe_end_s) begin
            we_q    <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            drive_q <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q - LW'(1);
            addr_q  <= addr_q + AW'(1);
            state_q <= ST_SETUP;
          end
        end
        ST_DONE: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          drive_q <= 1'b0;
          we_q    <= 1'b0;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdy_    = rdy_q   ? OD_ASSERT : OD_RELEASE;
  assign mem_we_ = we_q    ? OD_ASSERT : OD_RELEASE;
  assign abus    = drive_q ? addr_q : {AW{TS_RELEASE}};
  assign dbus    = drive_q ? data_q : {DW{TS_RELEASE}};
  assign busy    = busy_q;

endmodule
